// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Purpose:
//   Bridges the pipeline's single-word lw/sw requests onto a simple
//   synchronous-write, combinational-read data memory of 1 KB. Each request
//   is checked for alignment and range, optionally waits WAIT_CYCLES setup
//   cycles, performs one transfer cycle and then holds a response until the
//   pipeline takes it.
//
// Parameters:
//   WAIT_CYCLES        memory setup cycles before the transfer cycle (0..15)
//
// Ports:
//   clk                single clock, rising edge
//   rst_lsu_n          asynchronous active-low reset
//   req_valid/ready    request handshake (ready only while idle)
//   req_write          1 = store, 0 = load
//   req_addr           byte address
//   req_wdata          store data
//   resp_valid/ready   response handshake
//   resp_rdata         load data (zero for stores and errors)
//   resp_err           00 ok, 01 misaligned, 10 out of range
//   dm_addr            data memory address (latched request address)
//   dm_write_data      data memory write data (latched store data)
//   ctrl_dataMem_Write data memory write strobe, one cycle per legal store
//   ctrl_dataMem2reg   data memory read select, high while a load is in flight
//   dm_read_data       combinational read data from data memory
//   busy               high whenever the unit is not idle
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_lsu_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_write_data,
  output logic        ctrl_dataMem_Write,
  output logic        ctrl_dataMem2reg,
  input  logic [31:0] dm_read_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  localparam logic [1:0] ErrOk         = 2'b00;
  localparam logic [1:0] ErrMisaligned = 2'b01;
  localparam logic [1:0] ErrRange      = 2'b10;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic [31:0] rdata_q;
  logic [1:0]  err_q;

  logic accept;
  logic misaligned;
  logic outOfRange;

  assign accept     = req_valid && (state_q == IDLE);
  assign misaligned = (req_addr[1:0] != 2'b00);
  assign outOfRange = (req_addr[31:10] != 22'd0);

  // Request sequencing. Everything latched at accept stays frozen until the
  // next accept, so the memory sees a steady address/data for the whole
  // transaction and the response is stable while it waits for resp_ready.
  // resp_rdata is cleared at accept so stores and error responses return 0.
  always_ff @(posedge clk or negedge rst_lsu_n) begin
    if (!rst_lsu_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      write_q <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= ErrOk;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            write_q <= req_write;
            rdata_q <= 32'd0;
            if (misaligned) begin
              err_q   <= ErrMisaligned;
              state_q <= RESP;
            end else if (outOfRange) begin
              err_q   <= ErrRange;
              state_q <= RESP;
            end else begin
              err_q <= ErrOk;
              cnt_q <= WaitInit;
              if (WAIT_CYCLES == 0) begin
                state_q <= XFER;
              end else begin
                state_q <= WAIT;
              end
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= XFER;
          end
        end
        XFER: begin
          // Read data is sampled on the edge that closes the transfer cycle.
          rdata_q <= write_q ? 32'd0 : dm_read_data;
          state_q <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode directly from registered state so that an asynchronous
  // reset drops the write strobe immediately, before any clock edge.
  assign req_ready          = (state_q == IDLE);
  assign busy               = (state_q != IDLE);
  assign resp_valid         = (state_q == RESP);
  assign resp_rdata         = rdata_q;
  assign resp_err           = err_q;
  assign dm_addr            = addr_q;
  assign dm_write_data      = wdata_q;
  assign ctrl_dataMem_Write = (state_q == XFER) && write_q;
  assign ctrl_dataMem2reg   = ((state_q == WAIT) || (state_q == XFER)) && !write_q;

endmodule
